// File: rtl/truth_table_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_scanner_pkg
//  Description : Shared definitions for the truth-table scanner. This package
//                holds the scan FSM state encoding and the default expected
//                truth table.
//  Revision    : 1.0 - initial release
// ============================================================================
package truth_table_scanner_pkg;

    // Scan sequencer states. The encoding is fixed so that software and
    // debug probes can decode the state value.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_e;

    // Reference function: f = 1 for input vectors 2, 5, 7, 11, 13 and 14.
    localparam logic [15:0] DEFAULT_EXPECT = 16'h68A4;

endpackage : truth_table_scanner_pkg
`default_nettype wire

// File: rtl/truth_table_scanner_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_scanner_popcount
//  Description : Combinational population count. It returns the number of
//                set bits in bits_i.
//  Ports       : bits_i  [WIDTH-1:0]           vector to count
//                count_o [$clog2(WIDTH+1)-1:0] number of ones in bits_i
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_scanner_popcount #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]           bits_i,
    output logic [$clog2(WIDTH+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CNT_W'(bits_i[i]);
        end
    end

endmodule : truth_table_scanner_popcount
`default_nettype wire

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_scanner
//  Description : Sweeps every input combination through an external N_IN-input
//                combinational function. It waits SETTLE cycles per vector,
//                samples f_in, and then publishes the resulting truth table
//                together with its ones count and an EXPECT comparison.
//  Ports       : clk, rst           clock, synchronous active-high reset
//                start, abort       begin a scan / cancel a running scan
//                vec_out [N_IN-1:0] vector driven to the function under test
//                f_in               function response
//                busy, done         scan in progress / one-cycle completion
//                table_out          truth table of the last completed scan
//                ones_cnt           number of ones in table_out
//                match              table_out == EXPECT
//  Revision    : 1.0 - initial release
// ============================================================================
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int                     N_IN   = 4,
    parameter int                     SETTLE = 1,
    parameter logic [(2**N_IN)-1:0]   EXPECT = DEFAULT_EXPECT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [N_IN-1:0]       vec_out,
    input  logic                  f_in,
    output logic                  busy,
    output logic                  done,
    output logic [(2**N_IN)-1:0]  table_out,
    output logic [N_IN:0]         ones_cnt,
    output logic                  match
);

    localparam int TBL_W = 2 ** N_IN;
    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    scan_state_e        state_q, state_d;
    logic [N_IN-1:0]    vec_q,   vec_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [TBL_W-1:0]   work_q,  work_d;
    logic [TBL_W-1:0]   table_q, table_d;
    logic [N_IN:0]      ones_q,  ones_d;
    logic               match_q, match_d;
    logic [N_IN:0]      work_ones;

    truth_table_scanner_popcount #(
        .WIDTH (TBL_W)
    ) u_popcount (
        .bits_i  (work_q),
        .count_o (work_ones)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            table_q <= '0;
            ones_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            table_q <= table_d;
            ones_q  <= ones_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        table_d = table_q;
        ones_d  = ones_q;
        match_d = match_q;

        case (state_q)
            ST_IDLE: begin
                vec_d = '0;
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                    work_d  = '0;
                end
            end

            ST_DRIVE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                end else begin
                    work_d[vec_q] = f_in;
                    // Test for the last vector before incrementing, so the
                    // vector counter never wraps.
                    if (&vec_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRIVE;
                        vec_d   = vec_q + N_IN'(1);
                        cnt_d   = '0;
                    end
                end
            end

            ST_DONE: begin
                // work_q already holds the bit sampled in the last SAMPLE cycle
                table_d = work_q;
                ones_d  = work_ones;
                match_d = (work_q == EXPECT);
                vec_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                vec_d   = '0;
            end
        endcase
    end

    assign vec_out   = vec_q;
    assign busy      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done      = (state_q == ST_DONE);
    assign table_out = table_q;
    assign ones_cnt  = ones_q;
    assign match     = match_q;

endmodule : truth_table_scanner
`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_scanner
//  Description : Self-checking bench for truth_table_scanner. The function
//                under test is modelled as a lookup into fut_tbl, and the
//                expected results are computed directly from that table.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  vec_out;
    logic        f_in;
    logic        busy;
    logic        done;
    logic [15:0] table_out;
    logic [4:0]  ones_cnt;
    logic        match;

    logic [15:0] fut_tbl;
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    // External combinational function driven by the scanner's vector.
    assign f_in = fut_tbl[vec_out];

    truth_table_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .vec_out   (vec_out),
        .f_in      (f_in),
        .busy      (busy),
        .done      (done),
        .table_out (table_out),
        .ones_cnt  (ones_cnt),
        .match     (match)
    );

    function automatic int ref_ones(input logic [15:0] t);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(t[i]);
        return n;
    endfunction

    function automatic logic [15:0] default_fn();
        int ones_at[6] = '{2, 5, 7, 11, 13, 14};
        logic [15:0] t = '0;
        foreach (ones_at[k]) t[ones_at[k]] = 1'b1;
        return t;
    endfunction

    // Pulse start for cycle 0, then observe the scan from cycle 1 until done.
    // The task returns at the negedge after done, when the results are published.
    task automatic run_scan(output int done_cyc, output int busy_cnt, output bit order_ok);
        int cyc;
        done_cyc = -1;
        busy_cnt = 0;
        order_ok = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (cyc <= 200 && done_cyc < 0) begin
            if (busy) busy_cnt++;
            if (cyc <= 32 && vec_out !== 4'((cyc - 1) / 2)) order_ok = 1'b0;
            if (done) done_cyc = cyc;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_results(input string name, input logic [15:0] t);
        n_total++;
        if (table_out !== t) $display("FAIL %s table_out: got %h expected %h", name, table_out, t);
        else n_pass++;
        n_total++;
        if (ones_cnt !== 5'(ref_ones(t))) $display("FAIL %s ones_cnt: got %0d expected %0d", name, ones_cnt, ref_ones(t));
        else n_pass++;
        n_total++;
        if (match !== (t == 16'h68A4)) $display("FAIL %s match: got %b expected %b", name, match, (t == 16'h68A4));
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; fut_tbl = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({vec_out, busy, done, table_out, ones_cnt, match} !== '0)
            $display("FAIL reset outputs: got vec=%h busy=%b done=%b tbl=%h ones=%0d match=%b expected all 0",
                     vec_out, busy, done, table_out, ones_cnt, match);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_default();
        int dc, bc; bit ok;
        fut_tbl = default_fn();
        run_scan(dc, bc, ok);
        n_total++;
        if (dc !== 33) $display("FAIL default done_cycle: got %0d expected 33", dc);
        else n_pass++;
        n_total++;
        if (bc !== 32) $display("FAIL default busy_cycles: got %0d expected 32", bc);
        else n_pass++;
        n_total++;
        if (ok !== 1'b1) $display("FAIL default vec_order: got %b expected 1", ok);
        else n_pass++;
        check_results("default", 16'h68A4);
    endtask

    task automatic test_constant();
        int dc, bc; bit ok;
        fut_tbl = 16'hFFFF;
        run_scan(dc, bc, ok);
        check_results("all_ones", 16'hFFFF);
        fut_tbl = 16'h0000;
        run_scan(dc, bc, ok);
        check_results("all_zeros", 16'h0000);
    endtask

    task automatic test_random();
        int dc, bc; bit ok;
        for (int r = 0; r < 5; r++) begin
            fut_tbl = 16'($urandom);
            run_scan(dc, bc, ok);
            n_total++;
            if (dc !== 33) $display("FAIL random done_cycle: got %0d expected 33", dc);
            else n_pass++;
            check_results("random", fut_tbl);
        end
    endtask

    task automatic test_abort();
        int dc, bc; bit ok; bit saw_done;
        fut_tbl = default_fn();
        run_scan(dc, bc, ok);
        fut_tbl = 16'($urandom);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;          // cycle 1
        repeat (9) @(negedge clk);             // cycle 10
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;          // cycle 11
        n_total++;
        if (busy !== 1'b0 || vec_out !== 4'd0)
            $display("FAIL abort idle: got busy=%b vec=%h expected busy=0 vec=0", busy, vec_out);
        else n_pass++;
        saw_done = 1'b0;
        repeat (40) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        n_total++;
        if (saw_done !== 1'b0) $display("FAIL abort no_done: got done pulse expected none");
        else n_pass++;
        check_results("after_abort", 16'h68A4);
    endtask

    task automatic test_back_to_back();
        int cyc = 0; int found = 0; int exp_cyc[3] = '{33, 67, 101}; int got[3] = '{-1, -1, -1};
        fut_tbl = default_fn();
        @(negedge clk); start = 1'b1;          // cycle 0
        while (found < 3 && cyc < 150) begin
            @(negedge clk); cyc++;
            if (done) begin got[found] = cyc; found++; end
        end
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (got[k] !== exp_cyc[k]) $display("FAIL back_to_back done%0d: got %0d expected %0d", k, got[k], exp_cyc[k]);
            else n_pass++;
        end
        for (int k = 0; k < 100 && (busy || done); k++) @(negedge clk);
        @(negedge clk);
        check_results("back_to_back", 16'h68A4);
    endtask

    task automatic test_rst_mid();
        int dc, bc; bit ok;
        fut_tbl = 16'h1234;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;          // cycle 1
        repeat (19) @(negedge clk);            // cycle 20
        rst = 1'b1;
        @(negedge clk);                        // cycle 21
        n_total++;
        if ({vec_out, busy, done, table_out, ones_cnt, match} !== '0)
            $display("FAIL rst_mid outputs: got vec=%h busy=%b done=%b tbl=%h ones=%0d match=%b expected all 0",
                     vec_out, busy, done, table_out, ones_cnt, match);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        run_scan(dc, bc, ok);
        n_total++;
        if (dc !== 33) $display("FAIL rst_mid done_cycle: got %0d expected 33", dc);
        else n_pass++;
        check_results("after_rst", 16'h1234);
    endtask

    initial begin
        test_reset();
        test_default();
        test_constant();
        test_random();
        test_abort();
        test_back_to_back();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_truth_table_scanner
`default_nettype wire
